// File: rtl/split2_pkg.sv
// Shared definitions for the split2 router: FSM state encoding and destination codes.
package split2_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    HOLD     = 2'd2,
    DISPATCH = 2'd3
  } state_t;

  localparam logic DEST_A = 1'b0;
  localparam logic DEST_B = 1'b1;

endpackage

// File: rtl/split2_router.sv
// Moves one word at a time from a source buffer to buffer a or b, selected by din[ROUTE_BIT].
// Optional broadcast (din[ROUTE_BIT-1]) is enabled with macro SPLIT2_BROADCAST_EN.
module split2_router
  import split2_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ROUTE_BIT  = DATA_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  buffer_in_empty,
  output logic                  read_en,
  input  logic                  buffer_a_full,
  input  logic                  buffer_b_full,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  wen_a,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  wen_b
);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] hold, hold_next;
  logic [DATA_WIDTH-1:0] dout_a_next, dout_b_next;
  logic                  dest, dest_next;
  logic                  read_en_next, wen_a_next, wen_b_next;
`ifdef SPLIT2_BROADCAST_EN
  logic                  bcast, bcast_next;
  logic                  done_a, done_a_next;
  logic                  done_b, done_b_next;
`endif

  // All outputs are registered on the falling edge, like the neighbouring buffers.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      hold    <= '0;
      dest    <= DEST_A;
      read_en <= 1'b0;
      wen_a   <= 1'b0;
      wen_b   <= 1'b0;
      dout_a  <= '0;
      dout_b  <= '0;
`ifdef SPLIT2_BROADCAST_EN
      bcast   <= 1'b0;
      done_a  <= 1'b0;
      done_b  <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      hold    <= hold_next;
      dest    <= dest_next;
      read_en <= read_en_next;
      wen_a   <= wen_a_next;
      wen_b   <= wen_b_next;
      dout_a  <= dout_a_next;
      dout_b  <= dout_b_next;
`ifdef SPLIT2_BROADCAST_EN
      bcast   <= bcast_next;
      done_a  <= done_a_next;
      done_b  <= done_b_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    hold_next    = hold;
    dest_next    = dest;
    read_en_next = 1'b0;
    wen_a_next   = 1'b0;
    wen_b_next   = 1'b0;
    dout_a_next  = dout_a;
    dout_b_next  = dout_b;
`ifdef SPLIT2_BROADCAST_EN
    bcast_next   = bcast;
    done_a_next  = done_a;
    done_b_next  = done_b;
`endif

    case (state)
      IDLE: begin
        if (!buffer_in_empty) begin
          read_en_next = 1'b1;
          state_next   = FETCH;
        end
      end

      // The source presents din one edge after the strobe, so wait here.
      FETCH: begin
        state_next = HOLD;
      end

      HOLD: begin
        hold_next  = din;
        dest_next  = din[ROUTE_BIT];
`ifdef SPLIT2_BROADCAST_EN
        bcast_next  = din[ROUTE_BIT-1];
        done_a_next = 1'b0;
        done_b_next = 1'b0;
`endif
        state_next = DISPATCH;
      end

      DISPATCH: begin
`ifdef SPLIT2_BROADCAST_EN
        // Each port is served once as soon as it has room; leave when both are done.
        if (bcast) begin
          if (!done_a && !buffer_a_full) begin
            wen_a_next  = 1'b1;
            dout_a_next = hold;
            done_a_next = 1'b1;
          end
          if (!done_b && !buffer_b_full) begin
            wen_b_next  = 1'b1;
            dout_b_next = hold;
            done_b_next = 1'b1;
          end
          if (done_a_next && done_b_next) begin
            state_next = IDLE;
          end
        end else
`endif
        if (dest == DEST_A) begin
          if (!buffer_a_full) begin
            wen_a_next  = 1'b1;
            dout_a_next = hold;
            state_next  = IDLE;
          end
        end else begin
          if (!buffer_b_full) begin
            wen_b_next  = 1'b1;
            dout_b_next = hold;
            state_next  = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_split2_router.sv
// Scoreboard bench for split2_router: stimulus pushes expected writes, a monitor pops and checks them.
module tb_split2_router;

  localparam int DW     = 32;
  localparam int P_A    = 0;
  localparam int P_B    = 1;
  localparam int P_BOTH = 2;
  localparam int P_NONE = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] din;
  logic          buffer_in_empty;
  logic          read_en;
  logic          buffer_a_full;
  logic          buffer_b_full;
  logic [DW-1:0] dout_a;
  logic          wen_a;
  logic [DW-1:0] dout_b;
  logic          wen_b;

  typedef struct {
    logic [DW-1:0] data;
    bit            check_lat;
  } exp_t;

  typedef struct {
    bit port;
    int cyc;
  } wr_t;

  exp_t          exp_a[$];
  exp_t          exp_b[$];
  logic [DW-1:0] src_q[$];
  wr_t           wr_log[$];

  int n_cmp       = 0;
  int n_err       = 0;
  int cyc         = 0;
  int rd_cnt      = 0;
  int last_rd_cyc = 0;

  split2_router #(
    .DATA_WIDTH(DW),
    .ROUTE_BIT (DW - 1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .din            (din),
    .buffer_in_empty(buffer_in_empty),
    .read_en        (read_en),
    .buffer_a_full  (buffer_a_full),
    .buffer_b_full  (buffer_b_full),
    .dout_a         (dout_a),
    .wen_a          (wen_a),
    .dout_b         (dout_b),
    .wen_b          (wen_b)
  );

  always #5 clk = ~clk;

  // The design works on falling edges; cyc counts them.
  always @(negedge clk) cyc <= cyc + 1;

  task automatic reportFail(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    n_err++;
    $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // For P_BOTH only the b copy is latency-checked, since a is expected to be stalled.
  task automatic applyStimulus(input logic [DW-1:0] word, input int port, input bit lat);
    @(posedge clk);
    #1;
    src_q.push_back(word);
    if (port == P_A) exp_a.push_back('{word, lat});
    if (port == P_B) exp_b.push_back('{word, lat});
    if (port == P_BOTH) begin
      exp_a.push_back('{word, 1'b0});
      exp_b.push_back('{word, lat});
    end
  endtask

  task automatic waitDrain(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (exp_a.size() == 0 && exp_b.size() == 0) break;
      @(posedge clk);
    end
    if (exp_a.size() != 0 || exp_b.size() != 0)
      reportFail({name, "_timeout"}, exp_a.size() + exp_b.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic handleWrite(input bit port, input logic [DW-1:0] data);
    exp_t e;
    if (port == 1'b0) begin
      if (exp_a.size() == 0) begin
        reportFail("unexpected_wen_a", data, 0);
        return;
      end
      e = exp_a.pop_front();
    end else begin
      if (exp_b.size() == 0) begin
        reportFail("unexpected_wen_b", data, 0);
        return;
      end
      e = exp_b.pop_front();
    end
    checkOutput(port ? "dout_b" : "dout_a", data, e.data);
    if (e.check_lat)
      checkOutput(port ? "latency_b" : "latency_a", cyc - last_rd_cyc, 3);
    wr_log.push_back('{port, cyc});
  endtask

  // Source buffer model: pops a word when the strobe was registered on the previous falling edge.
  initial begin
    buffer_in_empty = 1'b1;
    din             = '0;
    forever begin
      @(posedge clk);
      if (read_en === 1'b1 && src_q.size() > 0) din = src_q.pop_front();
      buffer_in_empty = (src_q.size() == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (read_en === 1'b1) begin
        rd_cnt++;
        last_rd_cyc = cyc;
      end
      if (wen_a === 1'b1) handleWrite(1'b0, dout_a);
      if (wen_b === 1'b1) handleWrite(1'b1, dout_b);
`ifndef SPLIT2_BROADCAST_EN
      if (wen_a === 1'b1 && wen_b === 1'b1) reportFail("wen_both_high", 32'd3, 32'd1);
`endif
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int wbase;
    int drop_cyc;
    bit seen;

    reset         = 1'b1;
    buffer_a_full = 1'b0;
    buffer_b_full = 1'b0;
    #1;
    checkOutput("reset_read_en", read_en, 0);
    checkOutput("reset_wen_a", wen_a, 0);
    checkOutput("reset_wen_b", wen_b, 0);
    checkOutput("reset_dout_a", dout_a, 0);
    checkOutput("reset_dout_b", dout_b, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] route a");
    base = rd_cnt;
    applyStimulus(32'h0000_0005, P_A, 1'b1);
    waitDrain(40, "route_a");
    checkOutput("route_a_reads", rd_cnt - base, 1);
    checkOutput("route_a_dout_b_idle", dout_b, 32'h0000_0000);

    $display("[TB] route b");
    applyStimulus(32'h8000_0007, P_B, 1'b1);
    waitDrain(40, "route_b");
    checkOutput("route_b_dout_a_kept", dout_a, 32'h0000_0005);

    $display("[TB] backpressure");
    @(posedge clk);
    #1 buffer_b_full = 1'b1;
    base = rd_cnt;
    applyStimulus(32'h8000_0001, P_B, 1'b0);
    applyStimulus(32'h0000_0002, P_A, 1'b1);
    repeat (13) @(posedge clk);
    #1;
    checkOutput("stall_pending_b", exp_b.size(), 1);
    checkOutput("stall_reads", rd_cnt - base, 1);
    drop_cyc      = cyc;
    wbase         = wr_log.size();
    buffer_b_full = 1'b0;
    waitDrain(40, "backpressure");
    if (wr_log.size() >= wbase + 2) begin
      checkOutput("unstall_port", wr_log[wbase].port, 1);
      checkOutput("unstall_latency", wr_log[wbase].cyc - drop_cyc, 1);
    end else begin
      reportFail("unstall_writes", wr_log.size() - wbase, 2);
    end
    checkOutput("backpressure_reads", rd_cnt - base, 2);

    $display("[TB] reset mid-word");
    applyStimulus(32'h0000_00AA, P_NONE, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      if (read_en === 1'b1) seen = 1'b1;
    end
    if (!seen) reportFail("midword_read_timeout", 0, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("midreset_read_en", read_en, 0);
    checkOutput("midreset_wen_a", wen_a, 0);
    checkOutput("midreset_wen_b", wen_b, 0);
    checkOutput("midreset_dout_a", dout_a, 0);
    checkOutput("midreset_dout_b", dout_b, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(32'h0000_0033, P_A, 1'b1);
    waitDrain(40, "after_reset");
    checkOutput("after_reset_dout_b", dout_b, 32'h0000_0000);

    $display("[TB] stream");
    base  = rd_cnt;
    wbase = wr_log.size();
    applyStimulus(32'h0000_0011, P_A, 1'b1);
    applyStimulus(32'h8000_0022, P_B, 1'b1);
    applyStimulus(32'h0000_0044, P_A, 1'b1);
    applyStimulus(32'h8000_0088, P_B, 1'b1);
    waitDrain(100, "stream");
    checkOutput("stream_reads", rd_cnt - base, 4);
    if (wr_log.size() >= wbase + 4) begin
      for (int k = 1; k < 4; k++) begin
        checkOutput("stream_spacing", wr_log[wbase+k].cyc - wr_log[wbase+k-1].cyc, 4);
        checkOutput("stream_port", wr_log[wbase+k].port, k % 2);
      end
    end else begin
      reportFail("stream_writes", wr_log.size() - wbase, 4);
    end

`ifdef SPLIT2_BROADCAST_EN
    $display("[TB] broadcast");
    @(posedge clk);
    #1 buffer_a_full = 1'b1;
    base  = rd_cnt;
    wbase = wr_log.size();
    applyStimulus(32'h4000_0009, P_BOTH, 1'b1);
    for (int i = 0; i < 20 && exp_b.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    drop_cyc      = cyc;
    buffer_a_full = 1'b0;
    waitDrain(40, "broadcast");
    if (wr_log.size() >= wbase + 2) begin
      checkOutput("bcast_first_port", wr_log[wbase].port, 1);
      checkOutput("bcast_second_port", wr_log[wbase+1].port, 0);
      checkOutput("bcast_a_latency", wr_log[wbase+1].cyc - drop_cyc, 1);
    end else begin
      reportFail("bcast_writes", wr_log.size() - wbase, 2);
    end
    applyStimulus(32'h0000_0001, P_A, 1'b1);
    waitDrain(40, "after_bcast");
    checkOutput("bcast_reads", rd_cnt - base, 2);
`else
    $display("[TB] bit below route bit is plain data");
    base = rd_cnt;
    applyStimulus(32'h4000_0009, P_A, 1'b1);
    waitDrain(40, "plain_bit30");
    checkOutput("plain_bit30_reads", rd_cnt - base, 1);
    checkOutput("plain_bit30_dout_b", dout_b, 32'h8000_0088);
`endif

    repeat (5) @(posedge clk);
    #1;
    checkOutput("final_exp_a_empty", exp_a.size(), 0);
    checkOutput("final_exp_b_empty", exp_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/split2_router.md
SPLIT2_ROUTER -- requirements
Module: split2_router

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, the width of a data word.
REQ-002 The module SHALL have parameter ROUTE_BIT, default DATA_WIDTH-1, the din bit index that selects the destination (0 = port a, 1 = port b).
REQ-003 clk  input  1  single clock; all state updates on the falling edge, matching the sibling buffers.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 din  input  DATA_WIDTH  data from the source buffer, valid the edge after read_en.
REQ-006 buffer_in_empty  input  1  source buffer empty.
REQ-007 read_en  output  1  source buffer read strobe.
REQ-008 buffer_a_full  input  1  destination buffer a full.
REQ-009 buffer_b_full  input  1  destination buffer b full.
REQ-010 dout_a  output  DATA_WIDTH  data to buffer a.
REQ-011 wen_a  output  1  write strobe to buffer a.
REQ-012 dout_b  output  DATA_WIDTH  data to buffer b.
REQ-013 wen_b  output  1  write strobe to buffer b.

Function
REQ-014 The module SHALL implement the FSM states IDLE, FETCH, HOLD and DISPATCH.
- IDLE: if !buffer_in_empty -> read_en=1, go FETCH; else stay.
- FETCH: read_en=0, go HOLD.
- HOLD: latch din into the hold register, decode destination, go DISPATCH.
- DISPATCH: if the target is not full, drive dout_x=hold and wen_x=1 for one edge, then go IDLE; if the target is full, wen_x=0 and stay.
REQ-015 read_en SHALL be high for exactly one edge per word, and SHALL never be asserted outside IDLE.
REQ-016 Latency SHALL be fixed: read_en at edge n, data latched at edge n+2, earliest wen at edge n+3, giving a maximum throughput of one word per 4 edges.
REQ-017 wen_a and wen_b SHALL each be a single-edge pulse per write, and SHALL not both be high except under REQ-025.
REQ-018 dout_a and dout_b SHALL hold their last written value when not writing.
REQ-019 A full target SHALL stall only the FSM. No word SHALL be dropped or duplicated, and the non-target full flag SHALL be ignored.
REQ-020 Full deasserting in DISPATCH SHALL produce a write on the next edge.
REQ-021 A buffer_in_empty change outside IDLE SHALL have no effect.
REQ-022 The ROUTE_BIT field SHALL be passed through unmodified in dout.

Reset
REQ-023 When reset is asserted, the module SHALL asynchronously set state=IDLE, read_en=0, wen_a=0, wen_b=0, dout_a=0, dout_b=0 and hold=0.
REQ-024 Reset mid-operation SHALL discard the held word without writing it, and the FSM SHALL restart from IDLE on the first edge after deassertion.

Configuration
REQ-025 With macro SPLIT2_BROADCAST_EN defined, din bit ROUTE_BIT-1 = 1 SHALL select broadcast.
- In DISPATCH, each port is written independently when its own full flag is low.
- Per-port done flags prevent a second write to the same port.
- The FSM returns to IDLE once both ports are done; wen_a and wen_b may pulse on the same edge.
REQ-026 Without SPLIT2_BROADCAST_EN, bit ROUTE_BIT-1 SHALL be ordinary data, routing SHALL use ROUTE_BIT only, and no done-flag logic SHALL be present.

Structure
REQ-027 The FSM state encoding SHALL be placed in the shared package split2_pkg, together with constants DEST_A=0 and DEST_B=1.
REQ-028 The design SHALL be a single module with no sub-modules; the hold register and destination decode are inline.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Route a: src holds 0x0000_0005, both not full -> one read_en, then wen_a with dout_a=0x0000_0005 three edges later; wen_b stays 0.
- Route b: src holds 0x8000_0007 -> wen_b with dout_b=0x8000_0007; dout_a unchanged.
- Backpressure: buffer_b_full=1 during dispatch of 0x8000_0001 for 10 edges -> no wen_b, no further read_en; after full drops, exactly one wen_b with 0x8000_0001.
- Reset mid-word: reset asserted in HOLD -> all outputs 0 immediately, no write of the held word; after release, the next word is routed normally.
- Stream: 4 words alternating a/b, no full -> 4 read_en and 2 writes per port, in order, spaced 4 edges apart.
- Broadcast (SPLIT2_BROADCAST_EN): word 0x4000_0009 with buffer_a_full=1 for 3 edges -> wen_b first; wen_a after full drops; then return to IDLE with no duplicate writes.
